// File: rtl/stream_merge_pkg.sv
// Shared types for the two-input packet-locking stream merger.
package stream_merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } merge_state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } merge_src_t;

endpackage

// File: rtl/stream_merge2_if.sv
// Bundles both producer streams and the merged consumer stream of stream_merge2.
interface stream_merge2_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_a_data;
  logic                  in_a_last;
  logic                  in_a_valid;
  logic                  in_a_ready;
  logic [DATA_WIDTH-1:0] in_b_data;
  logic                  in_b_last;
  logic                  in_b_valid;
  logic                  in_b_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_src;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_a_data, in_a_last, in_a_valid,
    output in_a_ready,
    input  in_b_data, in_b_last, in_b_valid,
    output in_b_ready,
    output out_data, out_last, out_src, out_valid,
    input  out_ready
  );

  modport master (
    output in_a_data, in_a_last, in_a_valid,
    input  in_a_ready,
    output in_b_data, in_b_last, in_b_valid,
    input  in_b_ready,
    input  out_data, out_last, out_src, out_valid,
    output out_ready
  );
endinterface

// File: rtl/stream_out_reg.sv
// Registered output slot of the merger: one beat of {src, last, data} plus valid.
module stream_out_reg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             load_en
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  // Stage p1: beat accepted from an input, held until the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= din;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign load_en = !vld_p1 || out_ready;
  assign dout    = data_p1;
  assign vld     = vld_p1;

endmodule

// File: rtl/stream_merge2.sv
// Two-into-one ready/valid merger; a granted source keeps the output until its last beat.
module stream_merge2
  import stream_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  stream_merge2_if.slave    bus
);

  localparam int BEAT_W = DATA_WIDTH + 2;

  merge_state_t      state_q, state_d;
  merge_src_t        last_grant_q, last_grant_d;
  merge_src_t        grant;
  logic              load_en;
  logic              xfer_a, xfer_b;
  logic [BEAT_W-1:0] beat_p0;
  logic [BEAT_W-1:0] beat_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_B;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // In IDLE a tie goes to whichever source did not win last time
  always_comb begin
    grant = SRC_A;
    case (state_q)
      LOCK_A:  grant = SRC_A;
      LOCK_B:  grant = SRC_B;
      default: begin
        if (bus.in_b_valid && (!bus.in_a_valid || last_grant_q == SRC_A))
          grant = SRC_B;
      end
    endcase
  end

  assign bus.in_a_ready = !rst && load_en && (grant == SRC_A);
  assign bus.in_b_ready = !rst && load_en && (grant == SRC_B);
  assign xfer_a = bus.in_a_valid && bus.in_a_ready;
  assign xfer_b = bus.in_b_valid && bus.in_b_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (xfer_a) begin
          last_grant_d = SRC_A;
          if (!bus.in_a_last) state_d = LOCK_A;
        end else if (xfer_b) begin
          last_grant_d = SRC_B;
          if (!bus.in_b_last) state_d = LOCK_B;
        end
      end
      LOCK_A: if (xfer_a && bus.in_a_last) state_d = IDLE;
      LOCK_B: if (xfer_b && bus.in_b_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: beat selected from the granted source
  assign beat_p0 = (grant == SRC_B) ? {1'b1, bus.in_b_last, bus.in_b_data}
                                    : {1'b0, bus.in_a_last, bus.in_a_data};

  stream_out_reg #(.WIDTH(BEAT_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer_a || xfer_b),
    .din       (beat_p0),
    .out_ready (bus.out_ready),
    .dout      (beat_p1),
    .vld       (vld_p1),
    .load_en   (load_en)
  );

  // Stage p1: registered beat presented to the sink
  assign bus.out_data  = beat_p1[DATA_WIDTH-1:0];
  assign bus.out_last  = beat_p1[DATA_WIDTH];
  assign bus.out_src   = beat_p1[DATA_WIDTH+1];
  assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_stream_merge2.sv
// Bench for stream_merge2: readiness vector table, directed packet sequences, output scoreboard.
module tb_stream_merge2;

  logic clk;
  logic rst;

  stream_merge2_if #(.DATA_WIDTH(8)) ifc ();

  stream_merge2 #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic av;
    logic bv;
    logic ar;
    logic br;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];  // {src, last, data}
  beat_t      a_beats[$];
  beat_t      b_beats[$];
  vec_t       vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic src, input logic last, input logic [7:0] d);
    exp_q.push_back({src, last, d});
  endtask

  // Scoreboard: every beat the sink takes must be the next expected one
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: got 0x%0h, required no beat at %0t",
                 {ifc.out_src, ifc.out_last, ifc.out_data}, $time);
      end else begin
        chk("out_beat", {22'd0, ifc.out_src, ifc.out_last, ifc.out_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Drives queued beats on both inputs, honouring the handshake, within a cycle budget
  task automatic run_streams(input int budget);
    int   cyc = 0;
    logic hsa, hsb;
    beat_t dummy;
    while ((a_beats.size() > 0 || b_beats.size() > 0) && cyc < budget) begin
      ifc.in_a_valid = (a_beats.size() > 0);
      if (a_beats.size() > 0) begin
        ifc.in_a_data = a_beats[0].data;
        ifc.in_a_last = a_beats[0].last;
      end
      ifc.in_b_valid = (b_beats.size() > 0);
      if (b_beats.size() > 0) begin
        ifc.in_b_data = b_beats[0].data;
        ifc.in_b_last = b_beats[0].last;
      end
      #1;
      hsa = ifc.in_a_valid && ifc.in_a_ready;
      hsb = ifc.in_b_valid && ifc.in_b_ready;
      chk("one_ready", {31'd0, ifc.in_a_ready && ifc.in_b_ready}, 32'd0);
      tick();
      if (hsa) dummy = a_beats.pop_front();
      if (hsb) dummy = b_beats.pop_front();
      cyc++;
    end
    ifc.in_a_valid = 1'b0;
    ifc.in_b_valid = 1'b0;
    chk("stream_budget", a_beats.size() + b_beats.size(), 32'd0);
    a_beats.delete();
    b_beats.delete();
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    chk("drain", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{av: 1'b1, bv: 1'b1, ar: 1'b1, br: 1'b0};
    vecs[1] = '{av: 1'b1, bv: 1'b0, ar: 1'b1, br: 1'b0};
    vecs[2] = '{av: 1'b0, bv: 1'b1, ar: 1'b0, br: 1'b1};

    // Reset with both sources valid
    rst = 1'b1;
    ifc.out_ready  = 1'b1;
    ifc.in_a_valid = 1'b1;  ifc.in_a_data = 8'h11;  ifc.in_a_last = 1'b1;
    ifc.in_b_valid = 1'b1;  ifc.in_b_data = 8'h22;  ifc.in_b_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      chk("rst_a_ready", {31'd0, ifc.in_a_ready}, 32'd0);
      chk("rst_b_ready", {31'd0, ifc.in_b_ready}, 32'd0);
    end
    chk("rst_out_beat", {22'd0, ifc.out_src, ifc.out_last, ifc.out_data}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", {31'd0, ifc.in_a_ready}, 32'd1);
    chk("post_rst_b_ready", {31'd0, ifc.in_b_ready}, 32'd0);

    // Grant table in IDLE with last_grant=B, no clock edge between vectors
    for (int i = 0; i < 3; i++) begin
      ifc.in_a_valid = vecs[i].av;
      ifc.in_b_valid = vecs[i].bv;
      #1;
      chk($sformatf("vec%0d_a_ready", i), {31'd0, ifc.in_a_ready}, {31'd0, vecs[i].ar});
      chk($sformatf("vec%0d_b_ready", i), {31'd0, ifc.in_b_ready}, {31'd0, vecs[i].br});
    end
    ifc.in_a_valid = 1'b0;
    ifc.in_b_valid = 1'b0;
    tick();

    // Tie round-robin of single-beat packets
    for (int i = 0; i < 2; i++) begin
      a_beats.push_back('{last: 1'b1, data: 8'h11});
      b_beats.push_back('{last: 1'b1, data: 8'h22});
      push_exp(1'b0, 1'b1, 8'h11);
      push_exp(1'b1, 1'b1, 8'h22);
    end
    run_streams(20);
    wait_drain(20);

    // Lock: 3-beat packet from A is never interleaved with B
    a_beats.push_back('{last: 1'b0, data: 8'hA0});
    a_beats.push_back('{last: 1'b0, data: 8'hA1});
    a_beats.push_back('{last: 1'b1, data: 8'hA2});
    b_beats.push_back('{last: 1'b1, data: 8'h22});
    push_exp(1'b0, 1'b0, 8'hA0);
    push_exp(1'b0, 1'b0, 8'hA1);
    push_exp(1'b0, 1'b1, 8'hA2);
    push_exp(1'b1, 1'b1, 8'h22);
    run_streams(20);
    wait_drain(20);

    // Backpressure: held beat stays stable, inputs blocked
    ifc.out_ready  = 1'b0;
    ifc.in_a_valid = 1'b1;  ifc.in_a_data = 8'h5A;  ifc.in_a_last = 1'b1;
    ifc.in_b_valid = 1'b1;  ifc.in_b_data = 8'h33;  ifc.in_b_last = 1'b1;
    push_exp(1'b0, 1'b1, 8'h5A);
    #1;
    chk("bp_a_ready_first", {31'd0, ifc.in_a_ready}, 32'd1);
    tick();
    ifc.in_a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_out_valid", {31'd0, ifc.out_valid}, 32'd1);
      chk("bp_out_beat", {22'd0, ifc.out_src, ifc.out_last, ifc.out_data}, {22'd0, 2'b01, 8'h5A});
      chk("bp_a_ready", {31'd0, ifc.in_a_ready}, 32'd0);
      chk("bp_b_ready", {31'd0, ifc.in_b_ready}, 32'd0);
      tick();
    end
    ifc.in_b_valid = 1'b0;
    ifc.out_ready  = 1'b1;
    tick();
    #1;
    chk("bp_out_cleared", {31'd0, ifc.out_valid}, 32'd0);
    chk("bp_delivered_once", exp_q.size(), 32'd0);

    // Stall in lock: A opens a packet, then goes idle while B waits
    ifc.in_a_valid = 1'b1;  ifc.in_a_data = 8'hC0;  ifc.in_a_last = 1'b0;
    ifc.in_b_valid = 1'b0;
    push_exp(1'b0, 1'b0, 8'hC0);
    #1;
    chk("stall_a_first_ready", {31'd0, ifc.in_a_ready}, 32'd1);
    tick();
    ifc.in_a_valid = 1'b0;
    ifc.in_b_valid = 1'b1;  ifc.in_b_data = 8'h44;  ifc.in_b_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_b_ready", {31'd0, ifc.in_b_ready}, 32'd0);
      if (i > 0) chk("stall_out_valid", {31'd0, ifc.out_valid}, 32'd0);
      tick();
    end
    ifc.in_a_valid = 1'b1;  ifc.in_a_data = 8'hC1;  ifc.in_a_last = 1'b1;
    push_exp(1'b0, 1'b1, 8'hC1);
    #1;
    chk("stall_a_resume_ready", {31'd0, ifc.in_a_ready}, 32'd1);
    chk("stall_b_still_blocked", {31'd0, ifc.in_b_ready}, 32'd0);
    tick();
    ifc.in_a_valid = 1'b0;
    b_beats.push_back('{last: 1'b1, data: 8'h44});
    push_exp(1'b1, 1'b1, 8'h44);
    run_streams(20);
    wait_drain(20);

    // Reset while B holds the lock: held beat discarded, A wins next tie
    ifc.out_ready  = 1'b0;
    ifc.in_a_valid = 1'b0;
    ifc.in_b_valid = 1'b1;  ifc.in_b_data = 8'h66;  ifc.in_b_last = 1'b0;
    #1;
    chk("rm_b_ready", {31'd0, ifc.in_b_ready}, 32'd1);
    tick();
    ifc.in_b_data = 8'h67;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    ifc.in_a_valid = 1'b1;  ifc.in_a_data = 8'h77;  ifc.in_a_last = 1'b1;
    ifc.in_b_data  = 8'h88; ifc.in_b_last = 1'b1;
    ifc.out_ready  = 1'b1;
    #1;
    chk("rm_tie_a_ready", {31'd0, ifc.in_a_ready}, 32'd1);
    chk("rm_tie_b_ready", {31'd0, ifc.in_b_ready}, 32'd0);
    a_beats.push_back('{last: 1'b1, data: 8'h77});
    b_beats.push_back('{last: 1'b1, data: 8'h88});
    push_exp(1'b0, 1'b1, 8'h77);
    push_exp(1'b1, 1'b1, 8'h88);
    run_streams(20);
    wait_drain(20);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
